// File: rtl/memory_arbiter_if.sv
// Bundles the two requester channels and the memory read/write channels.
// slave is the arbiter's view; master is the environment's view.
interface memory_arbiter_if;
   logic        if_valid;
   logic [31:0] if_addr;
   logic        if_resp_valid;
   logic [31:0] if_resp_data;
   logic        if_resp_err;

   logic        d_valid;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_resp_valid;
   logic [31:0] d_resp_data;
   logic        d_resp_err;

   logic [31:0] mem_in_addr;
   logic [31:0] mem_in_data;
   logic        mem_in_valid;
   logic        mem_in_ready;
   logic [31:0] mem_out_addr;
   logic        mem_out_valid;
   logic [31:0] mem_out_data;
   logic        mem_out_ready;

   modport slave (
      input  if_valid, if_addr, d_valid, d_we, d_addr, d_wdata,
             mem_in_ready, mem_out_data, mem_out_ready,
      output if_resp_valid, if_resp_data, if_resp_err,
             d_resp_valid, d_resp_data, d_resp_err,
             mem_in_addr, mem_in_data, mem_in_valid,
             mem_out_addr, mem_out_valid
   );

   modport master (
      output if_valid, if_addr, d_valid, d_we, d_addr, d_wdata,
             mem_in_ready, mem_out_data, mem_out_ready,
      input  if_resp_valid, if_resp_data, if_resp_err,
             d_resp_valid, d_resp_data, d_resp_err,
             mem_in_addr, mem_in_data, mem_in_valid,
             mem_out_addr, mem_out_valid
   );
endinterface

// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing a single-port word memory between instruction
// fetch (read-only) and data (load/store); bad addresses are answered locally.
module memory_arbiter #(
   parameter int unsigned MEM_BIT_WIDTH = 16
) (
   input  logic            clk,
   input  logic            reset,
   memory_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   state_t      r_state;
   logic        r_last_d;
   logic        r_gnt_d;
   logic        r_we;
   logic        r_if_resp_valid;
   logic        r_if_resp_err;
   logic [31:0] r_if_resp_data;
   logic        r_d_resp_valid;
   logic        r_d_resp_err;
   logic [31:0] r_d_resp_data;
   logic        r_mem_in_valid;
   logic [31:0] r_mem_in_addr;
   logic [31:0] r_mem_in_data;
   logic        r_mem_out_valid;
   logic [31:0] r_mem_out_addr;

   logic        w_any;
   logic        w_pick_d;
   logic        w_we;
   logic        w_bad;
   logic        w_ready;
   logic [31:0] w_addr;
   logic [31:0] w_hi;

   // On a tie, data wins only if fetch was served last.
   assign w_any    = bus.if_valid | bus.d_valid;
   assign w_pick_d = bus.d_valid & (~bus.if_valid | ~r_last_d);
   assign w_addr   = w_pick_d ? bus.d_addr : bus.if_addr;
   assign w_we     = w_pick_d & bus.d_we;
   assign w_hi     = w_addr >> (MEM_BIT_WIDTH + 2);
   assign w_bad    = (w_addr[1:0] != 2'b00) | (w_hi != '0);
   assign w_ready  = r_we ? bus.mem_in_ready : bus.mem_out_ready;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state         <= IDLE;
         r_last_d        <= 1'b1;
         r_gnt_d         <= 1'b0;
         r_we            <= 1'b0;
         r_if_resp_valid <= 1'b0;
         r_if_resp_err   <= 1'b0;
         r_if_resp_data  <= '0;
         r_d_resp_valid  <= 1'b0;
         r_d_resp_err    <= 1'b0;
         r_d_resp_data   <= '0;
         r_mem_in_valid  <= 1'b0;
         r_mem_in_addr   <= '0;
         r_mem_in_data   <= '0;
         r_mem_out_valid <= 1'b0;
         r_mem_out_addr  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_any) begin
                  r_gnt_d  <= w_pick_d;
                  r_last_d <= w_pick_d;
                  r_we     <= w_we;
                  if (w_bad) begin
                     r_state <= DONE;
                     if (w_pick_d) begin
                        r_d_resp_valid <= 1'b1;
                        r_d_resp_err   <= 1'b1;
                     end else begin
                        r_if_resp_valid <= 1'b1;
                        r_if_resp_err   <= 1'b1;
                     end
                  end else begin
                     r_state <= WAIT;
                     if (w_we) begin
                        r_mem_in_valid <= 1'b1;
                        r_mem_in_addr  <= w_addr;
                        r_mem_in_data  <= bus.d_wdata;
                     end else begin
                        r_mem_out_valid <= 1'b1;
                        r_mem_out_addr  <= w_addr;
                     end
                  end
               end
            end
            WAIT: begin
               if (w_ready) begin
                  r_state         <= DONE;
                  r_mem_in_valid  <= 1'b0;
                  r_mem_out_valid <= 1'b0;
                  if (r_gnt_d) begin
                     r_d_resp_valid <= 1'b1;
                     r_d_resp_err   <= 1'b0;
                     if (!r_we) r_d_resp_data <= bus.mem_out_data;
                  end else begin
                     r_if_resp_valid <= 1'b1;
                     r_if_resp_err   <= 1'b0;
                     r_if_resp_data  <= bus.mem_out_data;
                  end
               end
            end
            DONE: begin
               r_state         <= IDLE;
               r_if_resp_valid <= 1'b0;
               r_d_resp_valid  <= 1'b0;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.if_resp_valid = r_if_resp_valid;
   assign bus.if_resp_data  = r_if_resp_data;
   assign bus.if_resp_err   = r_if_resp_err;
   assign bus.d_resp_valid  = r_d_resp_valid;
   assign bus.d_resp_data   = r_d_resp_data;
   assign bus.d_resp_err    = r_d_resp_err;
   assign bus.mem_in_valid  = r_mem_in_valid;
   assign bus.mem_in_addr   = r_mem_in_addr;
   assign bus.mem_in_data   = r_mem_in_data;
   assign bus.mem_out_valid = r_mem_out_valid;
   assign bus.mem_out_addr  = r_mem_out_addr;
endmodule

// File: tb/tb_memory_arbiter.sv
// Randomized bench for memory_arbiter: memory responder plus a transaction-level
// reference model (round-robin order, address legality, last-written memory contents).
module tb_memory_arbiter;
   localparam int unsigned MBW   = 16;
   localparam logic [31:0] LIMIT = 32'h1 << (MBW + 2);

   logic clk   = 1'b0;
   logic reset = 1'b0;

   memory_arbiter_if bus ();

   memory_arbiter #(.MEM_BIT_WIDTH(MBW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // ---------------- memory responder ----------------
   logic [31:0] mem     [0:65535];
   logic [31:0] exp_mem [0:65535];
   logic        rd_rdy, wr_rdy;
   logic        spur_rd = 1'b0, spur_wr = 1'b0;
   logic [31:0] rdata;
   int unsigned mem_lat = 1;
   int unsigned vcnt;
   int unsigned n_rd = 0, n_wr = 0, n_vcyc = 0;
   logic [31:0] last_rd_addr = '0, last_wr_addr = '0, last_wr_data = '0;

   assign bus.mem_out_ready = rd_rdy | spur_rd;
   assign bus.mem_in_ready  = wr_rdy | spur_wr;
   assign bus.mem_out_data  = rdata;

   function automatic logic [31:0] init_word(input int unsigned w);
      return (w * 32'h9E3779B1) ^ 32'h5A5A5A5A;
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_rdy <= 1'b0;
         wr_rdy <= 1'b0;
         vcnt   <= 0;
         rdata  <= '0;
      end else begin
         rd_rdy <= 1'b0;
         wr_rdy <= 1'b0;
         if (bus.mem_out_valid || bus.mem_in_valid) n_vcyc <= n_vcyc + 1;
         if (bus.mem_out_valid && !rd_rdy) begin
            if (vcnt + 1 >= mem_lat) begin
               rd_rdy       <= 1'b1;
               vcnt         <= 0;
               n_rd         <= n_rd + 1;
               last_rd_addr <= bus.mem_out_addr;
               rdata        <= mem[bus.mem_out_addr[17:2]];
            end else vcnt <= vcnt + 1;
         end else if (bus.mem_in_valid && !wr_rdy) begin
            if (vcnt + 1 >= mem_lat) begin
               wr_rdy       <= 1'b1;
               vcnt         <= 0;
               n_wr         <= n_wr + 1;
               last_wr_addr <= bus.mem_in_addr;
               last_wr_data <= bus.mem_in_data;
               mem[bus.mem_in_addr[17:2]] <= bus.mem_in_data;
            end else vcnt <= vcnt + 1;
         end
      end
   end

   // ---------------- reference model state ----------------
   bit last_d = 1'b1;
   int n_chk = 0, n_err = 0;

   function automatic bit is_bad(input logic [31:0] a);
      return (a[1:0] != 2'b00) || (a >= LIMIT);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] rand_addr();
      logic [31:0] a;
      case ($urandom_range(0, 7))
         0:       begin a = 32'($urandom_range(0, 63)) << 2; a = a | 32'($urandom_range(1, 3)); end
         1:       a = ($urandom | LIMIT) & ~32'h3;
         2:       a = LIMIT - 4;
         default: a = 32'($urandom_range(0, 31)) << 2;
      endcase
      return a;
   endfunction

   task automatic do_single(input bit is_d, input bit we, input logic [31:0] addr,
                            input logic [31:0] wdata);
      int unsigned rd0 = n_rd, wr0 = n_wr, vc0 = n_vcyc;
      int  k   = 0;
      bit  got = 1'b0;
      bit  bad = is_bad(addr);
      bit  rd  = !bad && !(is_d && we);
      bit  wr  = !bad && is_d && we;
      if (is_d) begin
         bus.d_valid = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata;
      end else begin
         bus.if_valid = 1'b1; bus.if_addr = addr;
      end
      while (!got && k < 40) begin
         @(negedge clk);
         k++;
         got = is_d ? bus.d_resp_valid : bus.if_resp_valid;
         chk("other_quiet", is_d ? bus.if_resp_valid : bus.d_resp_valid, 0);
      end
      chk("resp_seen", got, 1);
      chk("latency", k, bad ? 1 : 2 + mem_lat);
      chk("resp_err", is_d ? bus.d_resp_err : bus.if_resp_err, bad);
      if (rd) chk("resp_data", is_d ? bus.d_resp_data : bus.if_resp_data, exp_mem[addr[17:2]]);
      bus.if_valid = 1'b0;
      bus.d_valid  = 1'b0;
      last_d = is_d;
      if (wr) exp_mem[addr[17:2]] = wdata;
      chk("mem_reads", n_rd - rd0, rd);
      chk("mem_writes", n_wr - wr0, wr);
      chk("valid_cycles", n_vcyc - vc0, bad ? 0 : mem_lat + 1);
      if (rd) chk("rd_addr", last_rd_addr, addr);
      if (wr) begin
         chk("wr_addr", last_wr_addr, addr);
         chk("wr_data", last_wr_data, wdata);
      end
      @(negedge clk);
      chk("pulse_one_cycle", is_d ? bus.d_resp_valid : bus.if_resp_valid, 0);
   endtask

   task automatic do_pair(input bit d_we, input logic [31:0] d_addr, input logic [31:0] d_wdata,
                          input logic [31:0] f_addr);
      int k = 0, got = 0;
      bit nxt_d = !last_d;
      bus.d_valid = 1'b1; bus.d_we = d_we; bus.d_addr = d_addr; bus.d_wdata = d_wdata;
      bus.if_valid = 1'b1; bus.if_addr = f_addr;
      while (got < 2 && k < 60) begin
         @(negedge clk);
         k++;
         if (bus.if_resp_valid || bus.d_resp_valid) begin
            chk("pair_order", bus.d_resp_valid, nxt_d);
            if (nxt_d) begin
               chk("pair_d_err", bus.d_resp_err, is_bad(d_addr));
               if (!is_bad(d_addr) && !d_we) chk("pair_d_data", bus.d_resp_data, exp_mem[d_addr[17:2]]);
               if (!is_bad(d_addr) && d_we) exp_mem[d_addr[17:2]] = d_wdata;
               bus.d_valid = 1'b0;
            end else begin
               chk("pair_f_err", bus.if_resp_err, is_bad(f_addr));
               if (!is_bad(f_addr)) chk("pair_f_data", bus.if_resp_data, exp_mem[f_addr[17:2]]);
               bus.if_valid = 1'b0;
            end
            last_d = nxt_d;
            nxt_d  = !nxt_d;
            got++;
         end
      end
      chk("pair_count", got, 2);
      bus.if_valid = 1'b0;
      bus.d_valid  = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      #600000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int unsigned rd0, wr0;
      int k, got, last_t, cnt;
      bit nxt_d;

      for (int i = 0; i < 65536; i++) begin
         mem[i]     = init_word(i);
         exp_mem[i] = init_word(i);
      end
      bus.if_valid = 1'b0; bus.if_addr = '0;
      bus.d_valid  = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;

      // reset values
      repeat (3) @(negedge clk);
      chk("rst_if_resp_valid", bus.if_resp_valid, 0);
      chk("rst_d_resp_valid", bus.d_resp_valid, 0);
      chk("rst_errs", {bus.if_resp_err, bus.d_resp_err}, 0);
      chk("rst_mem_valids", {bus.mem_in_valid, bus.mem_out_valid}, 0);
      chk("rst_mem_out_addr", bus.mem_out_addr, 0);
      chk("rst_mem_in_addr", bus.mem_in_addr, 0);
      chk("rst_mem_in_data", bus.mem_in_data, 0);
      chk("rst_resp_data", bus.if_resp_data | bus.d_resp_data, 0);
      reset = 1'b1;
      @(negedge clk);

      // both held with reads: alternating grants, fetch first, 4 cycles apart
      bus.if_addr = 32'h40; bus.d_addr = 32'h44; bus.d_we = 1'b0;
      bus.if_valid = 1'b1; bus.d_valid = 1'b1;
      nxt_d = !last_d; got = 0; k = 0; last_t = 0;
      while (got < 8 && k < 100) begin
         @(negedge clk);
         k++;
         if (bus.if_resp_valid || bus.d_resp_valid) begin
            chk("stream_d", bus.d_resp_valid, nxt_d);
            chk("stream_f", bus.if_resp_valid, !nxt_d);
            chk("stream_data", nxt_d ? bus.d_resp_data : bus.if_resp_data,
                nxt_d ? exp_mem[32'h44 >> 2] : exp_mem[32'h40 >> 2]);
            if (got > 0) chk("stream_gap", k - last_t, 4);
            last_t = k;
            last_d = nxt_d;
            nxt_d  = !nxt_d;
            got++;
         end
      end
      chk("stream_count", got, 8);
      bus.if_valid = 1'b0; bus.d_valid = 1'b0;
      @(negedge clk);

      // directed fetch, store then load, errors
      mem[64] = 32'hDEADBEEF; exp_mem[64] = 32'hDEADBEEF;
      do_single(1'b0, 1'b0, 32'h100, '0);
      do_single(1'b1, 1'b1, 32'h20, 32'h12345678);
      do_single(1'b1, 1'b0, 32'h20, '0);
      do_single(1'b1, 1'b0, 32'h2, '0);
      do_single(1'b1, 1'b0, 32'h0004_0000, '0);
      do_single(1'b0, 1'b0, LIMIT - 4, '0);

      // stale valid: held through the resp cycle, dropped after it
      rd0 = n_rd; cnt = 0;
      bus.d_valid = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h20;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.d_resp_valid) begin
            cnt++;
            @(posedge clk);
            #1 bus.d_valid = 1'b0;
         end
      end
      chk("stale_resp_count", cnt, 1);
      chk("stale_reads", n_rd - rd0, 1);
      last_d = 1'b1;

      // spurious ready pulses while idle are ignored
      spur_rd = 1'b1; spur_wr = 1'b1;
      @(negedge clk);
      spur_rd = 1'b0; spur_wr = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("spur_no_resp", {bus.if_resp_valid, bus.d_resp_valid}, 0);
      end
      do_single(1'b0, 1'b0, 32'h20, '0);

      // reset asserted during WAIT
      mem_lat = 3; rd0 = n_rd; wr0 = n_wr;
      bus.if_valid = 1'b1; bus.if_addr = 32'h80;
      repeat (2) @(negedge clk);
      chk("wait_valid_before_rst", bus.mem_out_valid, 1);
      reset = 1'b0;
      #1 chk("rst_drops_valid", bus.mem_out_valid, 0);
      bus.if_valid = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (6) begin
         @(negedge clk);
         chk("no_resp_after_rst", {bus.if_resp_valid, bus.d_resp_valid}, 0);
      end
      chk("rst_no_access", (n_rd - rd0) + (n_wr - wr0), 0);
      last_d = 1'b1;
      mem_lat = 1;
      do_single(1'b0, 1'b0, 32'h80, '0);

      // randomized traffic
      for (int it = 0; it < 80; it++) begin
         mem_lat = $urandom_range(1, 3);
         case ($urandom_range(0, 3))
            0:       do_single(1'b0, 1'b0, rand_addr(), '0);
            1:       do_single(1'b1, $urandom_range(0, 1) != 0, rand_addr(), $urandom);
            default: do_pair($urandom_range(0, 1) != 0, rand_addr(), $urandom, rand_addr());
         endcase
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
Shares the single-port word memory between the instruction-fetch requester (read-only) and the data requester (load/store). One transaction at a time, round-robin when both requesters are pending.
Drives the memory's write channel (in_*) and read channel (out_*) with a hold-valid-until-ready handshake and returns one response pulse per request.
Range and alignment errors are rejected locally; such requests never reach memory.

Parameters:
MEM_BIT_WIDTH, 16, log2 of memory depth in words; valid byte addresses are 0 .. 2^(MEM_BIT_WIDTH+2)-1

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low (0 = in reset)
if_valid  in  1  fetch request; held until if_resp_valid
if_addr  in  32  fetch byte address
if_resp_valid  out  1  one-cycle response pulse
if_resp_data  out  32  fetched word; valid with if_resp_valid
if_resp_err  out  1  misaligned or out-of-range address; valid with if_resp_valid
d_valid  in  1  data request; held until d_resp_valid
d_we  in  1  1 = store, 0 = load
d_addr  in  32  data byte address
d_wdata  in  32  store data
d_resp_valid  out  1  one-cycle response pulse
d_resp_data  out  32  load data (undefined for stores)
d_resp_err  out  1  misaligned or out-of-range address
mem_in_addr  out  32  memory write address
mem_in_data  out  32  memory write data
mem_in_valid  out  1  memory write request
mem_in_ready  in  1  memory write done pulse
mem_out_addr  out  32  memory read address
mem_out_valid  out  1  memory read request
mem_out_data  in  32  memory read data
mem_out_ready  in  1  memory read done pulse

Behaviour:
- Reset (asynchronous, reset=0): state IDLE; last_grant=DATA (fetch wins first tie); all valid, resp and err outputs 0; data and address outputs 0. A memory ready pulse that arrives after reset while IDLE is ignored.
- States:
  - IDLE: sample if_valid and d_valid. Only one pending: grant it. Both pending: grant the requester not equal to last_grant. On grant: latch addr, we, wdata; update last_grant; run checks.
  - Error path: addr[1:0]!=0 or addr[31:MEM_BIT_WIDTH+2]!=0 → go to DONE with err=1; no memory valid is ever raised.
  - Good path: go to WAIT. Fetch and data loads drive mem_out_valid=1. Stores drive mem_in_valid=1.
  - WAIT: hold valid, addr and data stable until the matching ready is seen as 1. The opposite channel's ready is ignored. On the edge that ends WAIT: drop valid, capture mem_out_data for reads, go to DONE.
  - DONE: granted requester's resp_valid=1 for exactly one cycle, with data and err. Requester valids are not sampled. Next state is IDLE.
- Latency: request sampled in IDLE cycle c → mem valid high in cycles c+1..c+2 → resp in cycle c+3 → IDLE in c+4. Throughput is one transaction per 4 cycles. Error responses arrive in cycle c+1.
- The ready pulse from memory lasts one cycle. Valid drops on the following edge, so memory sees valid&&ready and never repeats the access.
- Requesters must deassert or change their request on the edge after their resp pulse. DONE guarantees no stale re-grant.
- resp_data and resp_err are held until the next response; only resp_valid pulses.
- Request inputs changing while not granted are don't-care. Inputs changing while granted have no effect because they are latched.
- Reset mid-WAIT: valid drops asynchronously and no response is issued. The requester reissues.

Test Plan:
- Fetch only, if_addr=0x100, memory word 64 = 0xDEADBEEF → mem_out_valid high 2 cycles at addr 0x100; if_resp_valid pulses in cycle c+3 with data 0xDEADBEEF, err=0.
- Store d_addr=0x20, d_wdata=0x12345678, then load 0x20 → exactly one mem_in_valid/mem_in_ready pair; load responds 0x12345678.
- if_valid and d_valid held continuously with reads → grants alternate F,D,F,D, starting with F after reset; 4 cycles per grant.
- d_addr=0x2 (misaligned) and d_addr=0x0004_0000 (MEM_BIT_WIDTH=16, out of range) → d_resp_err=1 one cycle after sampling; mem valids never asserted.
- Stale-valid check: requester holds d_valid through its resp cycle then drops it → exactly one memory access and one response.
- reset pulled low during WAIT → mem_out_valid=0 immediately; after release, no response pulse; next request is served normally.
